// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the RV32M multiply/divide unit
package muldiv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide between register-file read and write-back
// Operands are reduced to magnitudes at accept; signs are reapplied in FIN.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we_out
);

  state_e              state;
  funct3_e             fn;
  logic [CNT_W-1:0]    cnt;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     opb;
  logic [4:0]          rd;
  logic                neg_q;
  logic                neg_r;

  funct3_e             f_in;
  logic                a_neg;
  logic                b_neg;
  logic                div0;
  logic                ovf;
  logic [XLEN-1:0]     a_mag;
  logic [XLEN-1:0]     b_mag;

  always_comb begin
    f_in  = funct3_e'(funct3);
    a_neg = (f_in inside {MULH, MULHSU, DIV, REM}) && op_a[XLEN-1];
    b_neg = (f_in inside {MULH, DIV, REM}) && op_b[XLEN-1];
    a_mag = a_neg ? -op_a : op_a;
    b_mag = b_neg ? -op_b : op_b;
    div0  = funct3[2] && (op_b == '0);
    ovf   = (f_in inside {DIV, REM}) && (op_a == INT_MIN) && (op_b == '1);
  end

  // Multiply shifts right adding into the upper half; divide shifts left,
  // so acc[63:31] is the 33-bit partial remainder for the trial subtract.
  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_diff;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opb};
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fin_res;

  always_comb begin
    prod = neg_q ? -acc : acc;
    quot = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (fn)
      MUL:                 fin_res = prod[XLEN-1:0];
      MULH, MULHSU, MULHU: fin_res = prod[2*XLEN-1:XLEN];
      DIV, DIVU:           fin_res = quot;
      default:             fin_res = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      fn     <= MUL;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      rd     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
      we_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            fn   <= f_in;
            rd   <= rd_in;
            busy <= 1'b1;
            cnt  <= CNT_W'(XLEN - 1);
            opb  <= b_mag;
            // Special cases preload acc as {remainder, quotient} for FIN.
            if (div0) begin
              acc   <= {op_a, DIV0_QUOT};
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= FIN;
            end else if (ovf) begin
              acc   <= {{XLEN{1'b0}}, INT_MIN};
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= FIN;
            end else begin
              acc   <= {{XLEN{1'b0}}, a_mag};
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (fn[2]) begin
            if (!div_diff[XLEN]) acc <= {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else                 acc <= {acc[2*XLEN-2:0], 1'b0};
          end else begin
            acc <= {mul_sum, acc[XLEN-1:1]};
          end
          if (cnt == '0) state <= FIN;
          else           cnt   <= cnt - CNT_W'(1);
        end
        FIN: begin
          if (!done) begin
            result <= fin_res;
            rd_out <= rd;
            we_out <= (rd != '0);
            done   <= 1'b1;
          end else begin
            done   <= 1'b0;
            we_out <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        we_out;

  muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out),
    .we_out (we_out)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          pending = 0;
  int          acc_cyc = 0;
  int          exp_lat = 0;
  logic [31:0] exp_res = '0;
  logic [4:0]  exp_rd = '0;
  logic        exp_busy;
  logic        exp_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: plain 64-bit / signed-int arithmetic on the ISA rules.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    int          sa;
    int          sb;
    sa = a;
    sb = b;
    ea = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (f == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    case (f)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_busy = pending && cyc >= acc_cyc && cyc <= acc_cyc + exp_lat;
      exp_done = pending && cyc == acc_cyc + exp_lat;
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("we_out", 32'(we_out), 32'(exp_done && exp_rd != 0));
      if (exp_done) begin
        chk("result", result, exp_res);
        chk("rd_out", 32'(rd_out), 32'(exp_rd));
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    funct3  = f;
    op_a    = a;
    op_b    = b;
    rd_in   = rd;
    start   = 1'b1;
    exp_res = model(f, a, b);
    exp_rd  = rd;
    exp_lat = model_lat(f, a, b);
    acc_cyc = cyc + 1;
    pending = 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (done) seen = 1;
      else begin @(posedge clk); #1; end
    end
    if (seen) chk("latency", 32'(cyc - acc_cyc), 32'(exp_lat));
    else begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] lit);
    chk("model_pin", model(f, a, b), lit);
    issue(f, a, b, rd);
    wait_done();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(we_out), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    run(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
    run(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
    run(3'd0, 32'h1234_5678, 32'd0, 5'd4, 32'd0);
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD);
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF);
    run(3'd5, 32'd100, 32'd7, 5'd8, 32'd14);
    run(3'd7, 32'd100, 32'd7, 5'd9, 32'd2);
    run(3'd4, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF);
    run(3'd7, 32'd5, 32'd0, 5'd11, 32'd5);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0);
    run(3'd0, 32'd3, 32'd4, 5'd0, 32'd12);

    issue(3'd0, 32'd9, 32'd9, 5'd14);
    while (cyc < acc_cyc + 2) begin @(posedge clk); #1; end
    funct3 = 3'd5; op_a = 32'd50; op_b = 32'd5; rd_in = 5'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < acc_cyc + 32) begin @(posedge clk); #1; end
    start = 1'b1;
    wait_done();
    start = 1'b0;

    issue(3'd5, 32'd1000, 32'd3, 5'd15);
    while (cyc < acc_cyc + 10) begin @(posedge clk); #1; end
    rst = 1'b0;
    pending = 0;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    chk("async_we", 32'(we_out), 32'd0);
    chk("async_result", result, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    run(3'd5, 32'd1000, 32'd3, 5'd15, 32'd333);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
